// File: rtl/joy_db9_reader_if.sv
// DB9 joystick chain pins together with the published button word.
// The master modport is the reader; the slave modport is the connector/consumer side.
interface joy_db9_reader_if #(
  parameter int NBITS = 16
);
  logic             JOY_LOAD;
  logic             JOY_CLK;
  logic             JOY_DATA;
  logic [NBITS-1:0] joy_data;
  logic             joy_valid;
  logic             busy;

  modport master (
    output JOY_LOAD, JOY_CLK, joy_data, joy_valid, busy,
    input  JOY_DATA
  );

  modport slave (
    input  JOY_LOAD, JOY_CLK, joy_data, joy_valid, busy,
    output JOY_DATA
  );
endinterface

// File: rtl/joy_db9_reader.sv
// Master end of a 74HC165-style DB9 joystick chain: drives load/shift clock,
// deserializes the serial bits LSB first and publishes each frame with a strobe.
module joy_db9_reader #(
  parameter int CLK_DIV    = 8,
  parameter int NBITS      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             enable,
  joy_db9_reader_if.master joy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt;
  logic [NBITS-1:0] data_q, data_nxt;
  logic [1:0]       sync;
  logic             load_q, load_nxt;
  logic             clk_q, clk_nxt;
  logic             valid_q, valid_nxt;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // One tick per half period of the shift clock.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // JOY_DATA comes straight off the connector, so it is synchronized before use.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], joy.JOY_DATA};
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      shreg   <= '1;
      data_q  <= '0;
      load_q  <= 1'b1;
      clk_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      load_q  <= load_nxt;
      clk_q   <= clk_nxt;
      valid_q <= valid_nxt;
    end
  end

  // In LOAD the bit index doubles as the two-tick load-pulse counter.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    load_nxt  = load_q;
    clk_nxt   = clk_q;
    valid_nxt = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            load_nxt  = 1'b0;
            clk_nxt   = 1'b0;
            idx_nxt   = '0;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          if (idx == IDX_W'(1)) begin
            load_nxt  = 1'b1;
            idx_nxt   = '0;
            state_nxt = SHIFT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
        SHIFT: begin
          if (!clk_q) begin
            shreg_nxt[idx] = sync[1];
            clk_nxt        = 1'b1;
            if (idx == IDX_W'(NBITS - 1)) begin
              state_nxt = DONE;
            end
          end else begin
            clk_nxt = 1'b0;
            idx_nxt = idx + IDX_W'(1);
          end
        end
        DONE: begin
          data_nxt  = ACTIVE_LOW ? ~shreg : shreg;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign joy.JOY_LOAD  = load_q;
  assign joy.JOY_CLK   = clk_q;
  assign joy.joy_data  = data_q;
  assign joy.joy_valid = valid_q;
  assign joy.busy      = (state != IDLE);

endmodule
